// File: rtl/wb_sequencer_if.sv
// Writeback request and register-bank write bundle
// between the control unit and the writeback sequencer.
interface wb_sequencer_if;
  logic       start;
  logic [2:0] wb_class;
  logic [4:0] dest_reg;
  logic       mem_ready;
  logic       shift_done;
  logic       muldiv_done;
  logic [2:0] banco_write_data;
  logic       reg_write;
  logic [4:0] write_reg;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start,
    output wb_class,
    output dest_reg,
    output mem_ready,
    output shift_done,
    output muldiv_done,
    input  banco_write_data,
    input  reg_write,
    input  write_reg,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  wb_class,
    input  dest_reg,
    input  mem_ready,
    input  shift_done,
    input  muldiv_done,
    output banco_write_data,
    output reg_write,
    output write_reg,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: waits for the selected result source,
// then issues one register-bank write; boots $sp after reset.
module wb_sequencer #(
  parameter int TIMEOUT  = 64,
  parameter int SP_REG   = 29,
  parameter int LINK_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  wb_sequencer_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_BOOT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  localparam logic [2:0] C_ALU   = 3'd0;
  localparam logic [2:0] C_LOAD  = 3'd1;
  localparam logic [2:0] C_SHIFT = 3'd2;
  localparam logic [2:0] C_HI    = 3'd3;
  localparam logic [2:0] C_LO    = 3'd4;
  localparam logic [2:0] C_RSVD  = 3'd5;
  localparam logic [2:0] C_LINK  = 3'd6;
  localparam logic [2:0] C_LT    = 3'd7;

  localparam logic [2:0]    SEL_SP   = 3'd5;
  localparam logic [4:0]    SP_IDX   = 5'(SP_REG);
  localparam logic [4:0]    LINK_IDX = 5'(LINK_REG);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    class_q, class_d;
  logic [4:0]    dest_q, dest_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          accept;
  logic          src_ready;
  logic [4:0]    eff_reg;

  assign accept = (state_q == S_IDLE) && bus.start;

  always_comb begin
    src_ready = 1'b0;
    case (class_q)
      C_ALU:   src_ready = 1'b1;
      C_LOAD:  src_ready = bus.mem_ready;
      C_SHIFT: src_ready = bus.shift_done;
      C_HI:    src_ready = bus.muldiv_done;
      C_LO:    src_ready = bus.muldiv_done;
      C_RSVD:  src_ready = 1'b0;
      C_LINK:  src_ready = 1'b1;
      C_LT:    src_ready = 1'b1;
      default: src_ready = 1'b0;
    endcase
  end

  // Link writes always target the return-address register.
  assign eff_reg = (class_q == C_LINK) ? LINK_IDX : dest_q;

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_RST:  state_d = S_BOOT;
      S_BOOT: state_d = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          if (bus.wb_class == C_RSVD) begin
            state_d = S_ABORT;
            err_d   = 1'b1;
          end else begin
            state_d = S_WAIT;
            class_d = bus.wb_class;
            dest_d  = bus.dest_reg;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (src_ready) begin
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ABORT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      class_q <= '0;
      dest_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.banco_write_data = '0;
    bus.reg_write        = 1'b0;
    bus.write_reg        = '0;
    bus.busy             = 1'b0;
    bus.done             = 1'b0;
    bus.error            = err_q;
    case (state_q)
      S_BOOT: begin
        bus.banco_write_data = SEL_SP;
        bus.write_reg        = SP_IDX;
        bus.reg_write        = 1'b1;
        bus.busy             = 1'b1;
      end
      S_WAIT: begin
        bus.banco_write_data = class_q;
        bus.busy             = 1'b1;
      end
      S_WRITE: begin
        bus.banco_write_data = class_q;
        bus.write_reg        = eff_reg;
        bus.reg_write        = (eff_reg != 5'd0);
        bus.busy             = 1'b1;
        bus.done             = 1'b1;
      end
      S_ABORT: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: expected writes are queued
// at stimulus time and matched against each write/done cycle.
module tb_wb_sequencer;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] wreg;
    logic       we;
    logic       dn;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  wb_sequencer_if bus();

  wb_sequencer #(
    .TIMEOUT (64),
    .SP_REG  (29),
    .LINK_REG(31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk_wr(input logic [2:0] c, input logic [4:0] d,
                                 input int at);
    exp_t e;
    e.sel  = c;
    e.wreg = (c == 3'd6) ? 5'd31 : d;
    e.we   = (e.wreg != 5'd0);
    e.dn   = 1'b1;
    e.err  = 1'b0;
    e.cyc  = at;
    return e;
  endfunction

  function automatic exp_t mk_ab(input int at);
    exp_t e;
    e.sel  = 3'd0;
    e.wreg = 5'd0;
    e.we   = 1'b0;
    e.dn   = 1'b1;
    e.err  = 1'b1;
    e.cyc  = at;
    return e;
  endfunction

  function automatic exp_t mk_boot(input int at);
    exp_t e;
    e.sel  = 3'd5;
    e.wreg = 5'd29;
    e.we   = 1'b1;
    e.dn   = 1'b0;
    e.err  = 1'b0;
    e.cyc  = at;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset && (bus.reg_write || bus.done)) begin
      if (sbq.size() == 0) begin
        chk("unexp", {30'd0, bus.reg_write, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("cyc", cyc, e.cyc);
        chk("we", bus.reg_write, e.we);
        chk("done", bus.done, e.dn);
        chk("err", bus.error, e.err);
        if (!e.err) begin
          chk("sel", bus.banco_write_data, e.sel);
          chk("wreg", bus.write_reg, e.wreg);
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_tmo", ok, 1);
  endtask

  task automatic req(input logic [2:0] c, input logic [4:0] d);
    bus.start    = 1'b1;
    bus.wb_class = c;
    bus.dest_reg = d;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, bus.banco_write_data, 0);
    chk({tag, "_we"}, bus.reg_write, 0);
    chk({tag, "_wreg"}, bus.write_reg, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.error, 0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.wb_class    = 3'd0;
    bus.dest_reg    = 5'd0;
    bus.mem_ready   = 1'b0;
    bus.shift_done  = 1'b0;
    bus.muldiv_done = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b1;
    sbq.push_back(mk_boot(cyc + 1));
    wait_idle();
    chk("boot_done", bus.done, 0);
    chk("boot_we", bus.reg_write, 0);

    req(3'd0, 5'd8);
    sbq.push_back(mk_wr(3'd0, 5'd8, cyc + 1));
    wait_idle();

    req(3'd1, 5'd9);
    chk("ld_busy0", bus.busy, 1);
    chk("ld_wsel", bus.banco_write_data, 1);
    chk("ld_wwe", bus.reg_write, 0);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.wb_class = 3'd0;
    bus.dest_reg = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ld_busy1", bus.busy, 1);
    @(posedge clk); #1;
    chk("ld_busy2", bus.busy, 1);
    bus.mem_ready = 1'b1;
    sbq.push_back(mk_wr(3'd1, 5'd9, cyc + 1));
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    wait_idle();

    req(3'd6, 5'd5);
    sbq.push_back(mk_wr(3'd6, 5'd5, cyc + 1));
    wait_idle();
    req(3'd7, 5'd0);
    sbq.push_back(mk_wr(3'd7, 5'd0, cyc + 1));
    wait_idle();

    bus.shift_done = 1'b1;
    @(posedge clk); #1;
    bus.shift_done = 1'b0;
    req(3'd2, 5'd14);
    @(posedge clk); #1;
    chk("sh_busy", bus.busy, 1);
    bus.shift_done = 1'b1;
    sbq.push_back(mk_wr(3'd2, 5'd14, cyc + 1));
    @(posedge clk); #1;
    bus.shift_done = 1'b0;
    wait_idle();

    req(3'd3, 5'd10);
    sbq.push_back(mk_ab(cyc + 64));
    wait_idle();
    chk("err_sticky", bus.error, 1);
    bus.muldiv_done = 1'b1;
    req(3'd4, 5'd11);
    chk("err_clr", bus.error, 0);
    sbq.push_back(mk_wr(3'd4, 5'd11, cyc + 1));
    wait_idle();
    bus.muldiv_done = 1'b0;

    req(3'd5, 5'd6);
    sbq.push_back(mk_ab(cyc));
    wait_idle();
    chk("rsvd_err", bus.error, 1);

    req(3'd1, 5'd12);
    @(posedge clk); #1;
    chk("mid_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk_zero("mid");
    @(posedge clk); #1;
    reset = 1'b1;
    sbq.push_back(mk_boot(cyc + 1));
    wait_idle();

    req(3'd0, 5'd20);
    sbq.push_back(mk_wr(3'd0, 5'd20, cyc + 1));
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
